// File: rtl/memory_responder_pkg.sv
// Shared datapath definitions: default word width and the memory responder FSM encoding.
package memory_responder_pkg;
  localparam int DP_REG_SIZE = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } mr_state_e;
endpackage

// File: rtl/memory_responder_mem_array.sv
// Single-port synchronous RAM: write-enable, one address, registered read data.
module mem_array #(
  parameter int DW = 32,
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);
  // Contents are deliberately not reset.
  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
    rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/memory_responder.sv
// Wait-state memory responder: latches one MAR/MDR request, waits, accesses the RAM,
// and pulses mem_ready (with mem_err on dual/out-of-range requests).
module memory_responder
  import memory_responder_pkg::*;
#(
  parameter int REG_SIZE    = DP_REG_SIZE,
  parameter int ADDR_BITS   = 9,
  parameter int WAIT_STATES = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [REG_SIZE-1:0] mar_addr,
  input  logic [REG_SIZE-1:0] mdr_wdata,
  input  logic                read_req,
  input  logic                write_req,
  output logic [REG_SIZE-1:0] m_data_in,
  output logic                mem_ready,
  output logic                mem_err,
  output logic                busy
);
  mr_state_e             state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_BITS-1:0]  addr_q, addr_d;
  logic [REG_SIZE-1:0]   wdata_q, wdata_d;
  logic [REG_SIZE-1:0]   data_q, data_d;
  logic                  wr_q, wr_d;
  logic                  err_q, err_d;
  logic                  accept, req_err, ram_we, rd_ok;
  logic [REG_SIZE-1:0]   ram_rdata;

  assign accept  = (state_q == ST_IDLE) && (read_req || write_req);
  assign req_err = (read_req && write_req) || ((mar_addr >> ADDR_BITS) != '0);
  assign rd_ok   = !wr_q && !err_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    data_d  = data_q;
    wr_d    = wr_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: if (accept) begin
        addr_d  = mar_addr[ADDR_BITS-1:0];
        wdata_d = mdr_wdata;
        wr_d    = write_req;
        err_d   = req_err;
        if (WAIT_STATES == 0) state_d = ST_ACCESS;
        else begin
          state_d = ST_WAIT;
          cnt_d   = 4'(WAIT_STATES);
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = ST_ACCESS;
      end
      ST_ACCESS: state_d = ST_DONE;
      ST_DONE: begin
        state_d = ST_IDLE;
        // Capture the read so m_data_in holds it after the DONE cycle.
        if (rd_ok) data_d = ram_rdata;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != ST_IDLE);
    mem_ready = (state_q == ST_DONE);
    mem_err   = (state_q == ST_DONE) && err_q;
    ram_we    = (state_q == ST_ACCESS) && wr_q && !err_q;
    m_data_in = ((state_q == ST_DONE) && rd_ok) ? ram_rdata : data_q;
  end

  mem_array #(.DW(REG_SIZE), .AW(ADDR_BITS)) u_mem (
    .clk   (clk),
    .we    (ram_we),
    .addr  (addr_q),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );
endmodule

// File: tb/tb_memory_responder.sv
// Self-checking bench: directed table, randomized ops against an associative-array model,
// and hand sequences for busy-ignore, mid-op reset and zero wait states.
module tb_memory_responder;
  logic        clk = 1'b0, reset_n = 1'b0;
  logic [31:0] mar_addr = '0, mdr_wdata = '0, z_addr = '0, z_wdata = '0;
  logic        read_req = 1'b0, write_req = 1'b0, z_rd = 1'b0, z_wr = 1'b0;
  logic [31:0] m_data_in, z_data;
  logic        mem_ready, mem_err, busy, z_ready, z_err, z_busy;

  int tests = 0, fails = 0, cyc = 0;
  logic [31:0] ref_mem [int];
  logic [31:0] ref_data = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  memory_responder #(.REG_SIZE(32), .ADDR_BITS(9), .WAIT_STATES(2)) dut (
    .clk(clk), .reset_n(reset_n), .mar_addr(mar_addr), .mdr_wdata(mdr_wdata),
    .read_req(read_req), .write_req(write_req), .m_data_in(m_data_in),
    .mem_ready(mem_ready), .mem_err(mem_err), .busy(busy));

  memory_responder #(.REG_SIZE(32), .ADDR_BITS(9), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .mar_addr(z_addr), .mdr_wdata(z_wdata),
    .read_req(z_rd), .write_req(z_wr), .m_data_in(z_data),
    .mem_ready(z_ready), .mem_err(z_err), .busy(z_busy));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One request; returns edges from accept to the sampled mem_ready, err, data and accept cycle.
  task automatic apply(input bit sel, input bit rd, input bit wr, input logic [31:0] a,
                       input logic [31:0] d, output int lat, output logic e,
                       output logic [31:0] q, output int acc);
    @(negedge clk);
    if (!sel) begin read_req = rd; write_req = wr; mar_addr = a; mdr_wdata = d; end
    else      begin z_rd = rd; z_wr = wr; z_addr = a; z_wdata = d; end
    @(negedge clk);
    acc = cyc;
    read_req = 0; write_req = 0; z_rd = 0; z_wr = 0;
    lat = -1; e = 0; q = '0;
    for (int i = 1; i <= 20; i++) begin
      if (i > 1) @(negedge clk);
      if (sel ? z_ready : mem_ready) begin
        lat = i; e = sel ? z_err : mem_err; q = sel ? z_data : m_data_in;
        break;
      end
    end
    if (lat < 0) begin
      tests++; fails++;
      $display("FAIL timeout: no mem_ready within 20 cycles (addr %h)", a);
    end
  endtask

  // Model-checked operation on the WAIT_STATES=2 instance.
  task automatic run(input string name, input bit rd, input bit wr, input logic [31:0] a,
                     input logic [31:0] d);
    int lat, acc; logic e; logic [31:0] q;
    bit xerr, known;
    xerr  = (rd && wr) || (a >= 32'd512);
    known = 1'b1;
    if (!xerr && wr) ref_mem[int'(a)] = d;
    if (!xerr && rd) begin
      if (ref_mem.exists(int'(a))) ref_data = ref_mem[int'(a)];
      else known = 1'b0;
    end
    apply(0, rd, wr, a, d, lat, e, q, acc);
    chk({name, "_lat"}, lat, 4);
    chk({name, "_err"}, {31'b0, e}, {31'b0, xerr});
    if (known) chk({name, "_data"}, q, ref_data);
  endtask

  typedef struct {
    bit rd; bit wr; logic [31:0] a; logic [31:0] d; bit exp_err; logic [31:0] exp_data;
  } vec_t;

  initial begin
    vec_t tbl[10];
    int lat, acc, acc0, pulses;
    logic e; logic [31:0] q, pdata;

    tbl[0] = '{0, 1, 32'h5,        32'hDEADBEEF, 0, 32'h0};
    tbl[1] = '{1, 0, 32'h5,        32'h0,        0, 32'hDEADBEEF};
    tbl[2] = '{1, 0, 32'h200,      32'h0,        1, 32'hDEADBEEF};
    tbl[3] = '{0, 1, 32'h3,        32'h0000A5A5, 0, 32'hDEADBEEF};
    tbl[4] = '{1, 1, 32'h3,        32'h11112222, 1, 32'hDEADBEEF};
    tbl[5] = '{1, 0, 32'h3,        32'h0,        0, 32'h0000A5A5};
    tbl[6] = '{0, 1, 32'h1FF,      32'h5A5A5A5A, 0, 32'h0000A5A5};
    tbl[7] = '{1, 0, 32'h1FF,      32'h0,        0, 32'h5A5A5A5A};
    tbl[8] = '{0, 1, 32'h80000000, 32'h1,        1, 32'h5A5A5A5A};
    tbl[9] = '{1, 0, 32'h5,        32'h0,        0, 32'hDEADBEEF};

    #1;
    chk("rst_busy",  {31'b0, busy},      32'h0);
    chk("rst_ready", {31'b0, mem_ready}, 32'h0);
    chk("rst_err",   {31'b0, mem_err},   32'h0);
    chk("rst_data",  m_data_in,          32'h0);
    chk("rst_zbusy", {31'b0, z_busy},    32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    foreach (tbl[i]) begin
      apply(0, tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].d, lat, e, q, acc);
      chk($sformatf("vec%0d_lat", i), lat, 4);
      chk($sformatf("vec%0d_err", i), {31'b0, e}, {31'b0, tbl[i].exp_err});
      chk($sformatf("vec%0d_data", i), q, tbl[i].exp_data);
      if (!tbl[i].exp_err && tbl[i].wr) ref_mem[int'(tbl[i].a)] = tbl[i].d;
      if (!tbl[i].exp_err && tbl[i].rd) ref_data = tbl[i].exp_data;
    end

    for (int a = 16; a < 32; a++) run("fill", 0, 1, a, $urandom);
    for (int n = 0; n < 40; n++) begin
      int k; logic [31:0] a;
      k = $urandom_range(0, 9);
      a = 32'd16 + $urandom_range(0, 15);
      if (k == 0)      run("rnd_dual", 1, 1, a, $urandom);
      else if (k == 1) run("rnd_oor", 1, 0, $urandom | 32'h200, 0);
      else if (k < 6)  run("rnd_rd", 1, 0, a, 0);
      else             run("rnd_wr", 0, 1, a, $urandom);
    end

    // Write to 7 during WAIT of a read of 1 must be dropped.
    run("pre7", 0, 1, 7, 32'h77);
    run("pre1", 0, 1, 1, 32'h11);
    @(negedge clk); read_req = 1; mar_addr = 1;
    @(negedge clk); read_req = 0; write_req = 1; mar_addr = 7; mdr_wdata = 32'hBAD;
    pulses = 0; pdata = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      write_req = 0;
      if (mem_ready) begin pulses++; pdata = m_data_in; end
    end
    chk("busy_pulses", pulses, 1);
    chk("busy_data", pdata, 32'h11);
    ref_data = 32'h11;
    run("busy_rd7", 1, 0, 7, 0);

    // Reset in WAIT of a write aborts it and clears outputs at once.
    run("pre9", 0, 1, 9, 32'hCAFE);
    run("rd9", 1, 0, 9, 0);
    @(negedge clk); write_req = 1; mar_addr = 9; mdr_wdata = 32'h12345678;
    @(negedge clk); write_req = 0;
    #2 reset_n = 1'b0;
    #1;
    chk("mid_busy",  {31'b0, busy},      32'h0);
    chk("mid_ready", {31'b0, mem_ready}, 32'h0);
    chk("mid_err",   {31'b0, mem_err},   32'h0);
    chk("mid_data",  m_data_in,          32'h0);
    @(negedge clk); reset_n = 1'b1;
    ref_data = '0;
    run("rst_rd9", 1, 0, 9, 0);

    // Zero wait states: latency 2, back-to-back accepts 3 cycles apart.
    apply(1, 0, 1, 0, 32'h100, lat, e, q, acc);
    chk("z_wr0_lat", lat, 2);
    apply(1, 0, 1, 1, 32'h101, lat, e, q, acc);
    chk("z_wr1_lat", lat, 2);
    apply(1, 1, 0, 0, 0, lat, e, q, acc0);
    chk("z_rd0_lat", lat, 2);
    chk("z_rd0_data", q, 32'h100);
    apply(1, 1, 0, 1, 0, lat, e, q, acc);
    chk("z_rd1_lat", lat, 2);
    chk("z_rd1_data", q, 32'h101);
    chk("z_rd1_err", {31'b0, e}, 32'h0);
    chk("z_spacing", acc - acc0, 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/memory_responder.md
MEMORY_RESPONDER -- requirements
Module: memory_responder

Interface
REQ-001 SHALL have parameter REG_SIZE, default 32, giving the data and address word width.
REQ-002 SHALL have parameter ADDR_BITS, default 9, giving the implemented word-address bits (depth 2**ADDR_BITS words).
REQ-003 SHALL have parameter WAIT_STATES, default 2, giving the wait cycles inserted before each access (legal range 0..15).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port mar_addr, input, REG_SIZE bits: word address driven from the MAR register output.
REQ-007 SHALL have port mdr_wdata, input, REG_SIZE bits: write data driven from the MDR output.
REQ-008 SHALL have port read_req, input, 1 bit: read request.
REQ-009 SHALL have port write_req, input, 1 bit: write request.
REQ-010 SHALL have port m_data_in, output, REG_SIZE bits: read data returned to the MDR memory-side input.
REQ-011 SHALL have port mem_ready, output, 1 bit: one-cycle completion pulse.
REQ-012 SHALL have port mem_err, output, 1 bit: one-cycle error pulse, coincident with mem_ready.
REQ-013 SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-014 SHALL implement the FSM states IDLE, WAIT, ACCESS and DONE.
REQ-015 SHALL, in IDLE with read_req or write_req high at a rising edge, accept the request: latch mar_addr, mdr_wdata and the request type, then go to WAIT, or to ACCESS if WAIT_STATES=0.
REQ-016 SHALL, in WAIT, count exactly WAIT_STATES cycles using a 4-bit down-counter, then go to ACCESS.
REQ-017 SHALL, in ACCESS: on a write, store the latched data at the latched address; on a read, load m_data_in from the array; then go to DONE.
REQ-018 SHALL, in DONE, drive mem_ready=1 for exactly one cycle, then return to IDLE.
REQ-019 SHALL assert mem_ready exactly WAIT_STATES+2 rising edges after the accepting edge, with m_data_in valid in the same cycle.
REQ-020 SHALL ignore read_req and write_req while busy=1; no queuing.
REQ-021 SHALL treat read_req and write_req both high at acceptance as an error: no array access, m_data_in unchanged, mem_ready=1 and mem_err=1 in DONE.
REQ-022 SHALL treat a nonzero value in mar_addr bits [REG_SIZE-1:ADDR_BITS] as out of range: no access, m_data_in unchanged, mem_ready=1 and mem_err=1.
REQ-023 SHALL hold m_data_in at the last successful read value until the next successful read; writes do not change it.
REQ-024 SHALL allow a new request to be accepted in the IDLE cycle immediately after DONE, giving a back-to-back throughput of one access per WAIT_STATES+3 cycles.
REQ-025 SHALL return a write followed by a read of the same address the newly written data.

Reset
REQ-026 SHALL, while reset_n=0, force state=IDLE, wait counter=0, m_data_in=0, mem_ready=0, mem_err=0 and busy=0, immediately and independent of clk.
REQ-027 SHALL abort any access in progress when reset asserts; a write not yet in ACCESS SHALL leave the array unmodified.
REQ-028 SHALL NOT reset array contents; they are undefined until written.

Structure
REQ-029 SHALL place the FSM state encoding and the REG_SIZE default in the shared datapath package used by the datapath and its registers.
REQ-030 SHALL have one sub-module, mem_array: a single-port synchronous RAM with write enable, address, write data and registered read data.
REQ-031 SHALL keep the FSM, wait counter, request latches and error checks in memory_responder itself.

Verification
REQ-032 Write/read: write 0xDEADBEEF to address 5, then read address 5 -> m_data_in=0xDEADBEEF, mem_ready 4 edges after each accept (WAIT_STATES=2), mem_err=0.
REQ-033 Range error: read with mar_addr=0x00000200 -> mem_ready=1, mem_err=1, m_data_in keeps its prior value.
REQ-034 Dual request: read_req=1 and write_req=1 at address 3 -> mem_err=1, and a later read of address 3 returns its old contents.
REQ-035 Busy ignore: pulse write_req to address 7 during WAIT of a read of address 1 -> only one mem_ready pulse, and address 7 is unchanged.
REQ-036 Reset mid-op: assert reset_n=0 in WAIT of a write of 0x12345678 to address 9 -> all outputs 0 at once; a later read of address 9 does not return 0x12345678.
REQ-037 Zero wait: WAIT_STATES=0, back-to-back reads of addresses 0 and 1 -> mem_ready 2 edges after each accept, with accepts 3 cycles apart.
